// File: rtl/moisture_pkg.sv
// Shared definitions for the soil-moisture irrigation controller: state encoding,
// width helper and configuration sanity check.
package moisture_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WATER = 2'd1;
  localparam logic [1:0] ST_SOAK  = 2'd2;
  localparam logic [1:0] ST_FAULT = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    WATER = ST_WATER,
    SOAK  = ST_SOAK,
    FAULT = ST_FAULT
  } state_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'(1) << r) < 64'(v)) r = r + 1;
    return r;
  endfunction

  // True when thresholds are ordered and LVL_W can hold a full window count.
  function automatic bit cfg_ok(input int unsigned win, input int unsigned lvl_w,
                                input int unsigned dry, input int unsigned wet,
                                input int unsigned soak, input int unsigned max_on);
    return (win >= 2) && (lvl_w >= clog2(win + 1)) && (dry < wet) && (wet <= win)
           && (soak >= 1) && (max_on >= 1);
  endfunction

endpackage

// File: rtl/moisture_window_counter.sv
// Integrates wet samples over fixed windows; latches the count and pulses
// level_valid one cycle after the last sample of each window.
module moisture_window_counter
  import moisture_pkg::*;
#(
  parameter int unsigned WINDOW_CYCLES = 1024,
  parameter int unsigned LVL_W         = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             sensor_data,
  output logic             close_c,
  output logic [LVL_W-1:0] level_nxt_c,
  output logic [LVL_W-1:0] moisture_level,
  output logic             level_valid
);

  localparam int unsigned WIN_W = clog2(WINDOW_CYCLES);

  logic [WIN_W-1:0] win_cnt;
  logic [LVL_W-1:0] wet_cnt;

  assign close_c     = enable && (win_cnt == WIN_W'(WINDOW_CYCLES - 1));
  // Running count including the current sample, saturating at a full window.
  assign level_nxt_c = (wet_cnt == LVL_W'(WINDOW_CYCLES)) ? wet_cnt
                                                          : wet_cnt + LVL_W'(sensor_data);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win_cnt        <= '0;
      wet_cnt        <= '0;
      moisture_level <= '0;
      level_valid    <= 1'b0;
    end else if (!enable) begin
      win_cnt     <= '0;
      wet_cnt     <= '0;
      level_valid <= 1'b0;
    end else begin
      level_valid <= close_c;
      if (close_c) begin
        win_cnt        <= '0;
        wet_cnt        <= '0;
        moisture_level <= level_nxt_c;
      end else begin
        win_cnt <= win_cnt + WIN_W'(1);
        wet_cnt <= level_nxt_c;
      end
    end
  end

endmodule

// File: rtl/moisture_irrigation_ctrl.sv
// Irrigation pump controller: hysteresis FSM driven by windowed moisture level,
// with post-watering soak time and a sticky runaway-watering fault.
module moisture_irrigation_ctrl
  import moisture_pkg::*;
#(
  parameter int unsigned WINDOW_CYCLES = 1024,
  parameter int unsigned LVL_W         = 11,
  parameter int unsigned DRY_THRESH    = 4,
  parameter int unsigned WET_THRESH    = 7,
  parameter int unsigned MIN_SOAK_WIN  = 4,
  parameter int unsigned MAX_ON_WIN    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             sensor_data,
  input  logic             clear_fault,
  output logic [LVL_W-1:0] moisture_level,
  output logic             level_valid,
  output logic             pump_on,
  output logic             dry_alarm,
  output logic             fault
);

  localparam int unsigned ON_W   = clog2(MAX_ON_WIN + 1);
  localparam int unsigned SOAK_W = clog2(MIN_SOAK_WIN + 1);

  if (!cfg_ok(WINDOW_CYCLES, LVL_W, DRY_THRESH, WET_THRESH, MIN_SOAK_WIN, MAX_ON_WIN)) begin : g_bad_cfg
    $error("moisture_irrigation_ctrl: inconsistent threshold/width parameters");
  end

  logic             close_c;
  logic [LVL_W-1:0] level_nxt_c;
  state_t           state;
  logic [ON_W-1:0]  on_win;
  logic [SOAK_W-1:0] soak_win;

  moisture_window_counter #(
    .WINDOW_CYCLES (WINDOW_CYCLES),
    .LVL_W         (LVL_W)
  ) u_window (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .sensor_data    (sensor_data),
    .close_c        (close_c),
    .level_nxt_c    (level_nxt_c),
    .moisture_level (moisture_level),
    .level_valid    (level_valid)
  );

  // FSM acts on the level being latched this edge, so pump_on moves with level_valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      on_win    <= '0;
      soak_win  <= '0;
      pump_on   <= 1'b0;
      dry_alarm <= 1'b0;
      fault     <= 1'b0;
    end else begin
      if (close_c) dry_alarm <= (level_nxt_c < LVL_W'(DRY_THRESH));

      if (state == FAULT) begin
        if (clear_fault) begin
          state <= IDLE;
          fault <= 1'b0;
        end
      end else if (!enable) begin
        state    <= IDLE;
        on_win   <= '0;
        soak_win <= '0;
        pump_on  <= 1'b0;
      end else if (close_c) begin
        case (state)
          IDLE: begin
            if (level_nxt_c < LVL_W'(DRY_THRESH)) begin
              state   <= WATER;
              on_win  <= '0;
              pump_on <= 1'b1;
            end
          end
          WATER: begin
            on_win <= on_win + ON_W'(1);
            if (level_nxt_c >= LVL_W'(WET_THRESH)) begin
              state    <= SOAK;
              soak_win <= '0;
              pump_on  <= 1'b0;
            end else if (on_win + ON_W'(1) == ON_W'(MAX_ON_WIN)) begin
              state   <= FAULT;
              pump_on <= 1'b0;
              fault   <= 1'b1;
            end
          end
          SOAK: begin
            soak_win <= soak_win + SOAK_W'(1);
            if (soak_win + SOAK_W'(1) == SOAK_W'(MIN_SOAK_WIN)) state <= IDLE;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
